// File: rtl/output64.sv
// rtl/output64.sv - transmit framer: 64-bit words to a uart_tx byte stream
// Serialises words MSB byte first between an 8 x AA preamble and an 8 x 55 trailer.
module output64 #(
   parameter logic [7:0] PREAMBLE_BYTE = 8'hAA,
   parameter logic [7:0] TRAILER_BYTE  = 8'h55,
   parameter int         FRAME_BYTES   = 8,
   parameter int         HOLDOFF       = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startStream,
   input  logic        stopStream,
   input  logic [63:0] dataOutput,
   input  logic        dataOut64Valid,
   output logic        dataOut64Ready,
   input  logic        uart_tx_busy,
   output logic        uart_tx_en,
   output logic [7:0]  uart_tx_data,
   output logic        streamActive,
   output logic        dataOut64Done,
   output logic        errReserved
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PREAMBLE  = 3'd1;
   localparam logic [2:0] S_WAIT_WORD = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_TRAILER   = 3'd4;

   localparam logic [3:0]  LAST_IDX      = 4'(FRAME_BYTES - 1);
   localparam logic [3:0]  FULL_CNT      = 4'(FRAME_BYTES);
   localparam logic [1:0]  HOLD_LOAD     = 2'(HOLDOFF);
   // A word of all trailer bytes would look like a stop to the far end.
   localparam logic [63:0] RESERVED_WORD = {8{TRAILER_BYTE}};

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [3:0]  byte_cnt;
   logic [1:0]  holdoff;
   logic [63:0] shreg;
   logic        stop_lat;

   logic        pending;
   logic        issue;
   logic        last_issue;
   logic        accept;
   logic        reserved;
   logic        stop_any;
   logic [7:0]  issue_byte;

   always_comb begin
      pending    = (state == S_PREAMBLE || state == S_SEND || state == S_TRAILER)
                   && (byte_cnt < FULL_CNT);
      issue      = pending && !uart_tx_busy && (holdoff == 2'd0);
      last_issue = issue && (byte_cnt == LAST_IDX);
      accept     = (state == S_WAIT_WORD) && dataOut64Valid && dataOut64Ready;
      reserved   = (dataOutput == RESERVED_WORD);
      stop_any   = stop_lat || stopStream;

      case (state)
         S_PREAMBLE: issue_byte = PREAMBLE_BYTE;
         S_SEND:     issue_byte = shreg[63:56];
         default:    issue_byte = TRAILER_BYTE;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (startStream)
               state_next = S_PREAMBLE;
         end
         S_PREAMBLE, S_SEND: begin
            // A stop seen during a byte group only takes effect once the group is complete.
            if (last_issue)
               state_next = stop_any ? S_TRAILER : S_WAIT_WORD;
         end
         S_WAIT_WORD: begin
            if (accept && !reserved)
               state_next = S_SEND;
            else if (!accept && stop_any)
               state_next = S_TRAILER;
         end
         S_TRAILER: begin
            if (byte_cnt == FULL_CNT && holdoff == 2'd0 && !uart_tx_busy)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         byte_cnt       <= 4'd0;
         holdoff        <= 2'd0;
         shreg          <= 64'd0;
         stop_lat       <= 1'b0;
         uart_tx_en     <= 1'b0;
         uart_tx_data   <= 8'd0;
         dataOut64Ready <= 1'b0;
         streamActive   <= 1'b0;
         dataOut64Done  <= 1'b0;
         errReserved    <= 1'b0;
      end else begin
         state          <= state_next;
         uart_tx_en     <= issue;
         dataOut64Done  <= last_issue && (state == S_SEND);
         errReserved    <= accept && reserved;
         dataOut64Ready <= (state_next == S_WAIT_WORD);
         streamActive   <= (state_next != S_IDLE);

         // Holdoff masks the window before uart_tx_busy reflects a fresh load.
         if (issue) begin
            uart_tx_data <= issue_byte;
            holdoff      <= HOLD_LOAD;
         end else if (holdoff != 2'd0) begin
            holdoff <= holdoff - 2'd1;
         end

         if (state_next != state)
            byte_cnt <= 4'd0;
         else if (issue)
            byte_cnt <= byte_cnt + 4'd1;

         if (accept && !reserved)
            shreg <= dataOutput;
         else if (issue && state == S_SEND)
            shreg <= {shreg[55:0], 8'h00};

         if (state_next == S_TRAILER || state_next == S_IDLE)
            stop_lat <= 1'b0;
         else if (state != S_IDLE)
            stop_lat <= stop_lat | stopStream;
      end
   end

endmodule

// File: tb/tb_output64.sv
// tb/tb_output64.sv - self-checking bench for output64
// Expected byte stream is built from the framing rules; a uart model supplies busy.
module tb_output64;

   localparam logic [63:0] RES = 64'h5555555555555555;

   logic        clk = 1'b0;
   logic        reset;
   logic        startStream;
   logic        stopStream;
   logic [63:0] dataOutput;
   logic        dataOut64Valid;
   logic        dataOut64Ready;
   logic        uart_tx_busy;
   logic        uart_tx_en;
   logic [7:0]  uart_tx_data;
   logic        streamActive;
   logic        dataOut64Done;
   logic        errReserved;

   always #10 clk = ~clk;

   output64 dut (
      .clk            (clk),
      .reset          (reset),
      .startStream    (startStream),
      .stopStream     (stopStream),
      .dataOutput     (dataOutput),
      .dataOut64Valid (dataOut64Valid),
      .dataOut64Ready (dataOut64Ready),
      .uart_tx_busy   (uart_tx_busy),
      .uart_tx_en     (uart_tx_en),
      .uart_tx_data   (uart_tx_data),
      .streamActive   (streamActive),
      .dataOut64Done  (dataOut64Done),
      .errReserved    (errReserved)
   );

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [7:0] rx_bytes[$];
   logic [8:0] e_cur;
   int         strobes  = 0;
   int         done_cnt = 0;
   int         since_en = 100;
   int         busy_cnt = 0;
   logic       force_busy   = 1'b0;
   logic       busy_sampled = 1'b0;

   logic [7:0] word1_bytes [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

   assign uart_tx_busy = force_busy || (busy_cnt != 0);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // uart_tx model: roughly 10 cycles per byte; a loaded byte always runs to completion.
   always @(posedge clk) begin
      busy_sampled <= uart_tx_busy;
      if (uart_tx_en)
         busy_cnt <= 10;
      else if (busy_cnt != 0)
         busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clk) begin
      since_en++;
      if (uart_tx_en) begin
         strobes++;
         rx_bytes.push_back(uart_tx_data);
         chk("strobe_while_busy", 64'(busy_sampled), 64'd0);
         chk("holdoff_spacing", 64'(since_en >= 3), 64'd1);
         since_en = 0;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: actual byte %0h required no strobe", uart_tx_data);
         end else begin
            e_cur = exp_q.pop_front();
            chk("tx_byte", 64'(uart_tx_data), 64'(e_cur[7:0]));
            chk("done_on_strobe", 64'(dataOut64Done), 64'(e_cur[8]));
         end
      end else begin
         chk("done_without_strobe", 64'(dataOut64Done), 64'd0);
      end
      if (dataOut64Done)
         done_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_word(input logic [63:0] w);
      for (int k = 7; k >= 0; k--)
         exp_q.push_back({k == 0, w[k*8 +: 8]});
   endtask

   task automatic push_fill(input logic [7:0] b);
      for (int k = 0; k < 8; k++)
         exp_q.push_back({1'b0, b});
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (dataOut64Ready !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      ok = (dataOut64Ready === 1'b1);
      chk("ready_within_bound", 64'(dataOut64Ready), 64'd1);
   endtask

   task automatic wait_strobes(input int target);
      int n = 0;
      while (strobes < target && n < 500) begin
         tick();
         n++;
      end
      chk("strobe_count_reached", 64'(strobes), 64'(target));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || streamActive !== 1'b0) && n < 3000) begin
         tick();
         n++;
      end
      chk("stream_ends", 64'(streamActive), 64'd0);
      chk("all_bytes_sent", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic start_stream();
      rx_bytes.delete();
      push_fill(8'hAA);
      startStream = 1'b1;
      tick();
      startStream = 1'b0;
      chk("active_on_start", 64'(streamActive), 64'd1);
   endtask

   task automatic send_word(input logic [63:0] w, input bit with_stop);
      bit ok;
      wait_ready(ok);
      if (ok) begin
         dataOutput     = w;
         dataOut64Valid = 1'b1;
         stopStream     = with_stop;
         if (w != RES)
            push_word(w);
         if (with_stop)
            push_fill(8'h55);
         tick();
         dataOut64Valid = 1'b0;
         stopStream     = 1'b0;
         chk("err_reserved", 64'(errReserved), 64'(w == RES));
         chk("ready_after_accept", 64'(dataOut64Ready), 64'(w == RES));
         tick();
         chk("err_pulse_width", 64'(errReserved), 64'd0);
      end
   endtask

   task automatic send_stop();
      bit ok;
      wait_ready(ok);
      if (ok) begin
         stopStream = 1'b1;
         push_fill(8'h55);
         tick();
         stopStream = 1'b0;
         chk("ready_in_trailer", 64'(dataOut64Ready), 64'd0);
         chk("active_in_trailer", 64'(streamActive), 64'd1);
      end
   endtask

   // Receive-side view: strip the preamble, collect 8-byte words until a trailer group.
   task automatic check_stream(input int n, input logic [63:0] w0, input logic [63:0] w1,
                               input logic [63:0] w2);
      logic [63:0] g;
      logic [63:0] want;
      int          i;
      int          nw;
      bit          pre_ok;
      bit          tr_ok;
      pre_ok = (rx_bytes.size() >= 8);
      for (int k = 0; k < 8 && pre_ok; k++)
         if (rx_bytes[k] != 8'hAA)
            pre_ok = 0;
      chk("rx_preamble", 64'(pre_ok), 64'd1);
      i     = 8;
      nw    = 0;
      tr_ok = 0;
      while (i + 8 <= rx_bytes.size() && !tr_ok) begin
         g = 64'd0;
         for (int k = 0; k < 8; k++)
            g = {g[55:0], rx_bytes[i+k]};
         i += 8;
         if (g == RES) begin
            tr_ok = 1;
         end else begin
            want = (nw == 0) ? w0 : (nw == 1) ? w1 : w2;
            if (nw < n)
               chk("rx_word", g, want);
            nw++;
         end
      end
      chk("rx_trailer", 64'(tr_ok), 64'd1);
      chk("rx_no_extra_bytes", 64'(i), 64'(rx_bytes.size()));
      chk("rx_word_count", 64'(nw), 64'(n));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_en"},     64'(uart_tx_en),     64'd0);
      chk({tag, "_data"},   64'(uart_tx_data),   64'd0);
      chk({tag, "_ready"},  64'(dataOut64Ready), 64'd0);
      chk({tag, "_active"}, 64'(streamActive),   64'd0);
      chk({tag, "_done"},   64'(dataOut64Done),  64'd0);
      chk({tag, "_err"},    64'(errReserved),    64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int s0;
      int s1;
      reset          = 1'b1;
      startStream    = 1'b0;
      stopStream     = 1'b0;
      dataOutput     = 64'd0;
      dataOut64Valid = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      repeat (2) tick();
      chk("idle_active", 64'(streamActive), 64'd0);
      chk("idle_ready", 64'(dataOut64Ready), 64'd0);

      start_stream();
      wait_ready(ok);
      chk("preamble_strobes", 64'(strobes), 64'd8);
      chk("active_after_preamble", 64'(streamActive), 64'd1);
      send_word(64'h0123456789ABCDEF, 1'b0);
      wait_ready(ok);
      chk("word1_done_pulses", 64'(done_cnt), 64'd1);
      chk("word1_strobes", 64'(strobes), 64'd16);
      for (int k = 0; k < 8; k++)
         chk("word1_byte_order", 64'(rx_bytes[8+k]), 64'(word1_bytes[k]));
      send_word(64'hFEDCBA9876543210, 1'b0);
      send_word(64'h8000000000000001, 1'b0);
      send_stop();
      wait_idle();
      chk("ready_when_idle", 64'(dataOut64Ready), 64'd0);
      check_stream(3, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h8000000000000001);
      chk("stream1_done_pulses", 64'(done_cnt), 64'd3);

      start_stream();
      wait_ready(ok);
      s0 = strobes;
      send_word(RES, 1'b0);
      repeat (30) tick();
      chk("no_strobe_reserved", 64'(strobes), 64'(s0));
      chk("ready_after_reserved", 64'(dataOut64Ready), 64'd1);
      send_word(64'h0000000000000001, 1'b0);
      send_stop();
      wait_idle();
      check_stream(1, 64'h0000000000000001, 64'd0, 64'd0);

      start_stream();
      wait_ready(ok);
      s0 = strobes;
      send_word(64'hA1B2C3D4E5F60718, 1'b1);
      wait_strobes(s0 + 3);
      force_busy = 1'b1;
      s1 = strobes;
      repeat (50) tick();
      chk("no_strobe_while_busy", 64'(strobes), 64'(s1));
      force_busy = 1'b0;
      wait_idle();
      check_stream(1, 64'hA1B2C3D4E5F60718, 64'd0, 64'd0);
      chk("busy_stream_strobes", 64'(strobes - s0), 64'd16);

      start_stream();
      wait_ready(ok);
      s0 = strobes;
      send_word(64'h0F1E2D3C4B5A6978, 1'b0);
      wait_strobes(s0 + 3);
      reset = 1'b1;
      tick();
      chk_all_zero("reset_mid_send");
      exp_q.delete();
      reset = 1'b0;
      s1 = strobes;
      repeat (40) tick();
      chk("no_strobe_after_reset", 64'(strobes), 64'(s1));
      chk("idle_after_reset", 64'(streamActive), 64'd0);

      start_stream();
      wait_ready(ok);
      chk("restart_full_preamble", 64'(strobes - s1), 64'd8);
      send_stop();
      wait_idle();
      check_stream(0, 64'd0, 64'd0, 64'd0);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
